// File: rtl/snitch_vfpr_wb_if.sv
// Write-side, TCDM and retire signals of the VFPR write-back initiator.
// The slave modport is the initiator's view. The master modport is the environment's view.
interface snitch_vfpr_wb_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned TagWidth  = 5
);
   logic                   wb_valid_i;
   logic                   wb_ready_o;
   logic [AddrWidth-1:0]   wb_addr_i;
   logic [DataWidth-1:0]   wb_data_i;
   logic [TagWidth-1:0]    wb_tag_i;

   logic                   wr_q_valid_o;
   logic                   wr_q_ready_i;
   logic [AddrWidth-1:0]   wr_q_addr_o;
   logic [DataWidth-1:0]   wr_q_data_o;
   logic [DataWidth/8-1:0] wr_q_strb_o;
   logic                   wr_p_valid_i;

   logic                   done_valid_o;
   logic [TagWidth-1:0]    done_tag_o;

   modport slave (
      input  wb_valid_i, wb_addr_i, wb_data_i, wb_tag_i,
      output wb_ready_o,
      output wr_q_valid_o, wr_q_addr_o, wr_q_data_o, wr_q_strb_o,
      input  wr_q_ready_i, wr_p_valid_i,
      output done_valid_o, done_tag_o
   );

   modport master (
      output wb_valid_i, wb_addr_i, wb_data_i, wb_tag_i,
      input  wb_ready_o,
      input  wr_q_valid_o, wr_q_addr_o, wr_q_data_o, wr_q_strb_o,
      output wr_q_ready_i, wr_p_valid_i,
      input  done_valid_o, done_tag_o
   );
endinterface

// File: rtl/snitch_vfpr_wb.sv
// VFPR write-back initiator: it buffers FPU writes, issues them to the TCDM and retires tags in order.
// Define SNITCH_VFPR_WB_FWD_EN to forward the data of the youngest pending write on chk_data_o.
module snitch_vfpr_wb #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned TagWidth       = 5,
   parameter int unsigned BufDepth       = 4,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   snitch_vfpr_wb_if.slave      wb,
   input  logic [AddrWidth-1:0] chk_addr_i,
   output logic                 chk_hit_o,
   output logic [DataWidth-1:0] chk_data_o,
   input  logic                 flush_i,
   output logic                 idle_o,
   output logic                 err_o
);

   localparam int unsigned BufPtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned BufCntW = $clog2(BufDepth + 1);
   localparam int unsigned IfPtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned OutCntW = $clog2(MaxOutstanding + 1);

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] data;
      logic [TagWidth-1:0]  tag;
   } buf_entry_t;

   // An in-flight entry only needs its data when forwarding is enabled.
   typedef struct packed {
      logic [AddrWidth-1:0] addr;
`ifdef SNITCH_VFPR_WB_FWD_EN
      logic [DataWidth-1:0] data;
`endif
      logic [TagWidth-1:0]  tag;
   } if_entry_t;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

   buf_entry_t           buf_mem_q [BufDepth];
   buf_entry_t           buf_mem_d [BufDepth];
   if_entry_t            if_mem_q  [MaxOutstanding];
   if_entry_t            if_mem_d  [MaxOutstanding];
   logic [BufPtrW-1:0]   buf_wptr_q, buf_wptr_d, buf_rptr_q, buf_rptr_d;
   logic [BufCntW-1:0]   buf_cnt_q, buf_cnt_d;
   logic [IfPtrW-1:0]    if_wptr_q, if_wptr_d, if_rptr_q, if_rptr_d;
   logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
   logic                 done_valid_q, done_valid_d;
   logic [TagWidth-1:0]  done_tag_q, done_tag_d;
   logic                 err_q, err_d;
   state_e               state_q, state_d;

   buf_entry_t           buf_head;
   logic                 buf_empty, buf_full, wb_ready, push, issue_valid, issue, resp_ok;
   logic [BufPtrW-1:0]   buf_idx;
   logic [IfPtrW-1:0]    if_idx;

   assign buf_head    = buf_mem_q[buf_rptr_q];
   assign buf_empty   = (buf_cnt_q == '0);
   assign buf_full    = (buf_cnt_q == BufCntW'(BufDepth));
   assign wb_ready    = !buf_full && (state_q != DRAIN);
   assign push        = wb.wb_valid_i && wb_ready;
   assign issue_valid = !buf_empty && (out_cnt_q < OutCntW'(MaxOutstanding));
   assign issue       = issue_valid && wb.wr_q_ready_i;
   assign resp_ok     = wb.wr_p_valid_i && (out_cnt_q != '0);

   // NOTE: every always_comb target gets a default first so no path can infer a latch.
   always_comb begin
      buf_mem_d  = buf_mem_q;
      buf_wptr_d = buf_wptr_q;
      buf_rptr_d = buf_rptr_q;
      buf_cnt_d  = buf_cnt_q;
      if_mem_d   = if_mem_q;
      if_wptr_d  = if_wptr_q;
      if_rptr_d  = if_rptr_q;
      out_cnt_d  = out_cnt_q;

      if (push) begin
         buf_mem_d[buf_wptr_q] = '{addr: wb.wb_addr_i, data: wb.wb_data_i, tag: wb.wb_tag_i};
         buf_wptr_d = (buf_wptr_q == BufPtrW'(BufDepth - 1)) ? '0 : buf_wptr_q + 1'b1;
      end
      if (issue) begin
         buf_rptr_d = (buf_rptr_q == BufPtrW'(BufDepth - 1)) ? '0 : buf_rptr_q + 1'b1;
         if_mem_d[if_wptr_q].addr = buf_head.addr;
`ifdef SNITCH_VFPR_WB_FWD_EN
         if_mem_d[if_wptr_q].data = buf_head.data;
`endif
         if_mem_d[if_wptr_q].tag  = buf_head.tag;
         if_wptr_d = (if_wptr_q == IfPtrW'(MaxOutstanding - 1)) ? '0 : if_wptr_q + 1'b1;
      end
      if (resp_ok) begin
         if_rptr_d = (if_rptr_q == IfPtrW'(MaxOutstanding - 1)) ? '0 : if_rptr_q + 1'b1;
      end

      unique case ({push, issue})
         2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
         2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
         default: buf_cnt_d = buf_cnt_q;
      endcase
      unique case ({issue, resp_ok})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_comb begin
      done_valid_d = resp_ok;
      done_tag_d   = resp_ok ? if_mem_q[if_rptr_q].tag : done_tag_q;
      err_d        = err_q | (wb.wr_p_valid_i && (out_cnt_q == '0));

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (push) state_d = ACTIVE;
         ACTIVE: begin
            if (flush_i) state_d = DRAIN;
            else if (buf_empty && (out_cnt_q == '0) && !push) state_d = IDLE;
         end
         DRAIN:   if (buf_empty && (out_cnt_q == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The hazard scan goes oldest to newest, in-flight first, so the youngest match is the one kept.
   always_comb begin
      chk_hit_o  = 1'b0;
      chk_data_o = '0;
      if_idx     = '0;
      buf_idx    = '0;
      for (int k = 0; k < int'(MaxOutstanding); k++) begin
         if_idx = IfPtrW'((int'(if_rptr_q) + k) % int'(MaxOutstanding));
         if ((k < int'(out_cnt_q)) && (if_mem_q[if_idx].addr == chk_addr_i)) begin
            chk_hit_o = 1'b1;
`ifdef SNITCH_VFPR_WB_FWD_EN
            chk_data_o = if_mem_q[if_idx].data;
`endif
         end
      end
      for (int k = 0; k < int'(BufDepth); k++) begin
         buf_idx = BufPtrW'((int'(buf_rptr_q) + k) % int'(BufDepth));
         if ((k < int'(buf_cnt_q)) && (buf_mem_q[buf_idx].addr == chk_addr_i)) begin
            chk_hit_o = 1'b1;
`ifdef SNITCH_VFPR_WB_FWD_EN
            chk_data_o = buf_mem_q[buf_idx].data;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_wptr_q   <= '0;
         buf_rptr_q   <= '0;
         buf_cnt_q    <= '0;
         if_wptr_q    <= '0;
         if_rptr_q    <= '0;
         out_cnt_q    <= '0;
         done_valid_q <= 1'b0;
         done_tag_q   <= '0;
         err_q        <= 1'b0;
         state_q      <= IDLE;
      end else begin
         buf_wptr_q   <= buf_wptr_d;
         buf_rptr_q   <= buf_rptr_d;
         buf_cnt_q    <= buf_cnt_d;
         if_wptr_q    <= if_wptr_d;
         if_rptr_q    <= if_rptr_d;
         out_cnt_q    <= out_cnt_d;
         done_valid_q <= done_valid_d;
         done_tag_q   <= done_tag_d;
         err_q        <= err_d;
         state_q      <= state_d;
      end
   end

   // NOTE: payload storage is not reset. Each entry is qualified by the pointers and counts, which are reset.
   always_ff @(posedge clk_i) begin
      buf_mem_q <= buf_mem_d;
      if_mem_q  <= if_mem_d;
   end

   assign wb.wb_ready_o   = wb_ready;
   assign wb.wr_q_valid_o = issue_valid;
   assign wb.wr_q_addr_o  = buf_head.addr;
   assign wb.wr_q_data_o  = buf_head.data;
   assign wb.wr_q_strb_o  = '1;
   assign wb.done_valid_o = done_valid_q;
   assign wb.done_tag_o   = done_tag_q;
   assign idle_o          = (state_q == IDLE);
   assign err_o           = err_q;

endmodule

// File: tb/tb_snitch_vfpr_wb.sv
// Directed self-checking bench for snitch_vfpr_wb. It covers issue, backpressure, the outstanding limit,
// overlapping issue and response, the hazard check, flush, error and mid-operation reset.
module tb_snitch_vfpr_wb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned TW = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [AW-1:0] chk_addr_i;
   logic          chk_hit_o;
   logic [DW-1:0] chk_data_o;
   logic          flush_i;
   logic          idle_o;
   logic          err_o;
   int            n_checks = 0;
   int            n_errors = 0;

   snitch_vfpr_wb_if #(.AddrWidth(AW), .DataWidth(DW), .TagWidth(TW)) wb_if ();

   snitch_vfpr_wb #(
      .AddrWidth(AW), .DataWidth(DW), .TagWidth(TW), .BufDepth(4), .MaxOutstanding(4)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wb         (wb_if),
      .chk_addr_i (chk_addr_i),
      .chk_hit_o  (chk_hit_o),
      .chk_data_o (chk_data_o),
      .flush_i    (flush_i),
      .idle_o     (idle_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
      wb_if.wb_valid_i = v;
      wb_if.wb_addr_i  = a;
      wb_if.wb_data_i  = d;
      wb_if.wb_tag_i   = t;
   endtask

   initial begin
      logic [DW-1:0] fwd_b, fwd_c, fwd_dead;
`ifdef SNITCH_VFPR_WB_FWD_EN
      fwd_b = 64'hB; fwd_c = 64'hC; fwd_dead = 64'hDEAD;
`else
      fwd_b = '0;    fwd_c = '0;    fwd_dead = '0;
`endif
      rst_ni = 1'b0;
      flush_i = 1'b0;
      chk_addr_i = '0;
      drive_wb(1'b0, '0, '0, '0);
      wb_if.wr_q_ready_i = 1'b0;
      wb_if.wr_p_valid_i = 1'b0;

      // Values while reset is held
      #12;
      check("rst_wb_ready", 64'(wb_if.wb_ready_o), 64'd1);
      check("rst_q_valid", 64'(wb_if.wr_q_valid_o), 64'd0);
      check("rst_done_valid", 64'(wb_if.done_valid_o), 64'd0);
      check("rst_done_tag", 64'(wb_if.done_tag_o), 64'd0);
      check("rst_chk_hit", 64'(chk_hit_o), 64'd0);
      check("rst_chk_data", chk_data_o, 64'd0);
      check("rst_idle", 64'(idle_o), 64'd1);
      check("rst_err", 64'(err_o), 64'd0);
      step();
      rst_ni = 1'b1;
      step();

      // 1: a single write through to retire
      drive_wb(1'b1, 32'h10, 64'hDEAD, 5'd3);
      check("t1_no_fallthrough", 64'(wb_if.wr_q_valid_o), 64'd0);
      step();
      drive_wb(1'b0, '0, '0, '0);
      check("t1_q_valid", 64'(wb_if.wr_q_valid_o), 64'd1);
      check("t1_q_addr", 64'(wb_if.wr_q_addr_o), 64'h10);
      check("t1_q_data", wb_if.wr_q_data_o, 64'hDEAD);
      check("t1_q_strb", 64'(wb_if.wr_q_strb_o), 64'hFF);
      check("t1_busy", 64'(idle_o), 64'd0);
      wb_if.wr_q_ready_i = 1'b1;
      step();
      wb_if.wr_q_ready_i = 1'b0;
      check("t1_q_valid_after", 64'(wb_if.wr_q_valid_o), 64'd0);
      chk_addr_i = 32'h10;
      #1;
      check("t1_inflight_hit", 64'(chk_hit_o), 64'd1);
      check("t1_inflight_data", chk_data_o, fwd_dead);
      step();
      wb_if.wr_p_valid_i = 1'b1;
      step();
      wb_if.wr_p_valid_i = 1'b0;
      check("t1_done_valid", 64'(wb_if.done_valid_o), 64'd1);
      check("t1_done_tag", 64'(wb_if.done_tag_o), 64'd3);
      check("t1_retired_no_hit", 64'(chk_hit_o), 64'd0);
      step();
      check("t1_done_once", 64'(wb_if.done_valid_o), 64'd0);
      check("t1_idle", 64'(idle_o), 64'd1);

      // 2: the buffer fills while the TCDM port is stalled
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 32'h100 + 32'(i * 8), 64'h1000 + 64'(i), 5'(i));
         check($sformatf("t2_ready_%0d", i), 64'(wb_if.wb_ready_o), 64'd1);
         step();
      end
      drive_wb(1'b1, 32'h120, 64'h1004, 5'd4);
      check("t2_full_not_ready", 64'(wb_if.wb_ready_o), 64'd0);
      step();
      step();
      check("t2_still_full", 64'(wb_if.wb_ready_o), 64'd0);
      check("t2_hold_valid", 64'(wb_if.wr_q_valid_o), 64'd1);
      check("t2_hold_addr", 64'(wb_if.wr_q_addr_o), 64'h100);
      check("t2_hold_data", wb_if.wr_q_data_o, 64'h1000);

      // 3: the outstanding limit
      wb_if.wr_q_ready_i = 1'b1;
      step();
      step();
      drive_wb(1'b0, '0, '0, '0);
      step();
      step();
      check("t3_limit_valid", 64'(wb_if.wr_q_valid_o), 64'd0);
      step();
      check("t3_limit_hold", 64'(wb_if.wr_q_valid_o), 64'd0);
      wb_if.wr_p_valid_i = 1'b1;
      step();
      wb_if.wr_p_valid_i = 1'b0;
      check("t3_done_tag0", 64'(wb_if.done_tag_o), 64'd0);
      check("t3_done_valid", 64'(wb_if.done_valid_o), 64'd1);
      check("t3_fifth_valid", 64'(wb_if.wr_q_valid_o), 64'd1);
      check("t3_fifth_addr", 64'(wb_if.wr_q_addr_o), 64'h120);
      step();
      check("t3_fifth_issued", 64'(wb_if.wr_q_valid_o), 64'd0);
      check("t3_done_pulse", 64'(wb_if.done_valid_o), 64'd0);

      // 4: an issue and a response in the same cycle
      drive_wb(1'b1, 32'h128, 64'h1005, 5'd5);
      step();
      drive_wb(1'b0, '0, '0, '0);
      check("t4_blocked", 64'(wb_if.wr_q_valid_o), 64'd0);
      wb_if.wr_p_valid_i = 1'b1;
      step();
      check("t4_tag1", 64'(wb_if.done_tag_o), 64'd1);
      check("t4_valid_again", 64'(wb_if.wr_q_valid_o), 64'd1);
      step();
      check("t4_overlap_done", 64'(wb_if.done_valid_o), 64'd1);
      check("t4_tag2", 64'(wb_if.done_tag_o), 64'd2);
      check("t4_buf_empty", 64'(wb_if.wr_q_valid_o), 64'd0);
      for (int t = 3; t <= 5; t++) begin
         step();
         check($sformatf("t4_tag%0d", t), 64'(wb_if.done_tag_o), 64'(t));
         check($sformatf("t4_valid%0d", t), 64'(wb_if.done_valid_o), 64'd1);
      end
      wb_if.wr_p_valid_i = 1'b0;
      check("t4_no_err", 64'(err_o), 64'd0);
      step();
      step();
      check("t4_idle", 64'(idle_o), 64'd1);

      // 5: the hazard check and forwarding priority
      wb_if.wr_q_ready_i = 1'b0;
      drive_wb(1'b1, 32'h20, 64'hA, 5'd7);
      step();
      wb_if.wr_q_ready_i = 1'b1;
      drive_wb(1'b1, 32'h20, 64'hB, 5'd8);
      step();
      wb_if.wr_q_ready_i = 1'b0;
      drive_wb(1'b0, '0, '0, '0);
      chk_addr_i = 32'h20;
      #1;
      check("t5_hit", 64'(chk_hit_o), 64'd1);
      check("t5_buf_over_inflight", chk_data_o, fwd_b);
      chk_addr_i = 32'h24;
      #1;
      check("t5_miss", 64'(chk_hit_o), 64'd0);
      check("t5_miss_data", chk_data_o, 64'd0);
      drive_wb(1'b1, 32'h20, 64'hC, 5'd9);
      step();
      drive_wb(1'b0, '0, '0, '0);
      chk_addr_i = 32'h20;
      #1;
      check("t5_newest_in_buf", chk_data_o, fwd_c);

      // 6: flush with 2 buffered and 1 in flight, then a stray response
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("t6_drain_not_ready", 64'(wb_if.wb_ready_o), 64'd0);
      check("t6_drain_busy", 64'(idle_o), 64'd0);
      wb_if.wr_q_ready_i = 1'b1;
      wb_if.wr_p_valid_i = 1'b1;
      for (int t = 7; t <= 9; t++) begin
         step();
         check($sformatf("t6_tag%0d", t), 64'(wb_if.done_tag_o), 64'(t));
         check($sformatf("t6_not_ready%0d", t), 64'(wb_if.wb_ready_o), 64'd0);
      end
      wb_if.wr_p_valid_i = 1'b0;
      wb_if.wr_q_ready_i = 1'b0;
      check("t6_err_clear", 64'(err_o), 64'd0);
      step();
      check("t6_idle", 64'(idle_o), 64'd1);
      check("t6_ready_back", 64'(wb_if.wb_ready_o), 64'd1);
      wb_if.wr_p_valid_i = 1'b1;
      step();
      wb_if.wr_p_valid_i = 1'b0;
      check("t6_err_set", 64'(err_o), 64'd1);
      check("t6_stray_no_done", 64'(wb_if.done_valid_o), 64'd0);
      step();
      check("t6_err_sticky", 64'(err_o), 64'd1);

      // Reset in the middle of operation
      drive_wb(1'b1, 32'h40, 64'h4, 5'd1);
      step();
      drive_wb(1'b0, '0, '0, '0);
      chk_addr_i = 32'h40;
      #1;
      check("rm_pending_hit", 64'(chk_hit_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("rm_q_valid", 64'(wb_if.wr_q_valid_o), 64'd0);
      check("rm_err", 64'(err_o), 64'd0);
      check("rm_idle", 64'(idle_o), 64'd1);
      check("rm_hit", 64'(chk_hit_o), 64'd0);
      step();
      rst_ni = 1'b1;
      step();
      check("rm_after_q_valid", 64'(wb_if.wr_q_valid_o), 64'd0);
      check("rm_after_done", 64'(wb_if.done_valid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
